sensor_mod5_scheduler: RTL and testbench

- Time-shares one combinational remainder-by-5 unit (4-bit input, 3-bit remainder 0..4, Resto5-equivalent) among N_CH sensor channels.
- Round-robin arbitration across channels; each channel uses a valid/ready handshake.
- One remainder is in flight at a time. Result leaves on a valid/ready output tagged with the source channel.
- Sits between the sensor front-ends and downstream consumers of the remainder.

---
 rtl/sensor_mod5_scheduler.sv | 117 +++++++++++
 tb/tb_sensor_mod5_scheduler.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/sensor_mod5_scheduler.sv
// Round-robin scheduler that time-shares one remainder-by-5 unit among N_CH
// sensor channels, with one conversion in flight and a channel-tagged result.
module sensor_mod5_scheduler #(
   parameter int N_CH  = 4,
   parameter int CNT_W = 8,
   localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [N_CH-1:0]   req_valid,
   input  logic [4*N_CH-1:0] req_data,
   output logic [N_CH-1:0]   req_ready,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [2:0]        out_rem,
   output logic [CH_W-1:0]   out_ch,
   output logic              busy,
   output logic [CNT_W-1:0]  conv_cnt,
   output logic [1:0]        state_dbg
);

   // Handshakes: a transfer happens on a rising edge where valid && ready are
   // both high; a valid source holds its data stable until that edge.
   typedef enum logic [1:0] {IDLE = 2'd0, COMPUTE = 2'd1, HOLD = 2'd2} state_t;

   state_t          state, state_nxt;
   logic [CH_W-1:0] rr_ptr, ch_reg, grant_idx, cand_idx;
   logic [CH_W:0]   cand_sum;
   logic            grant_found;
   logic [3:0]      operand, grant_data;
   logic [2:0]      rem_calc;

   // First requesting channel at or after rr_ptr, wrapping modulo N_CH.
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      cand_sum    = '0;
      cand_idx    = '0;
      for (int k = 0; k < N_CH; k++) begin
         cand_sum = {1'b0, rr_ptr} + (CH_W+1)'(k);
         if (cand_sum >= (CH_W+1)'(N_CH))
            cand_sum = cand_sum - (CH_W+1)'(N_CH);
         cand_idx = cand_sum[CH_W-1:0];
         if (!grant_found && req_valid[cand_idx]) begin
            grant_found = 1'b1;
            grant_idx   = cand_idx;
         end
      end
   end

   always_comb begin
      grant_data = '0;
      for (int c = 0; c < N_CH; c++)
         if (grant_idx == CH_W'(c))
            grant_data = req_data[4*c +: 4];
   end

   always_comb begin
      req_ready = '0;
      if (rst_n && state == IDLE && grant_found)
         req_ready[grant_idx] = 1'b1;
   end

   assign rem_calc  = 3'(operand % 4'd5);
   assign busy      = (state != IDLE);
   assign state_dbg = state;

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (grant_found) state_nxt = COMPUTE;
         COMPUTE: state_nxt = HOLD;
         HOLD:    if (out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rr_ptr    <= '0;
         ch_reg    <= '0;
         operand   <= '0;
         out_valid <= 1'b0;
         out_rem   <= '0;
         out_ch    <= '0;
         conv_cnt  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (grant_found) begin
                  operand <= grant_data;
                  ch_reg  <= grant_idx;
                  rr_ptr  <= (grant_idx == CH_W'(N_CH-1)) ? '0 : grant_idx + 1'b1;
               end
            end
            COMPUTE: begin
               out_rem   <= rem_calc;
               out_ch    <= ch_reg;
               out_valid <= 1'b1;
            end
            HOLD: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  conv_cnt  <= conv_cnt + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_sensor_mod5_scheduler.sv
// Bench for sensor_mod5_scheduler: vector table, directed sequences, and
// random traffic checked every cycle against a transaction-level model.
module tb_sensor_mod5_scheduler;

   localparam int N_CH = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [3:0]  req_valid = '0;
   logic [15:0] req_data = '0;
   logic        out_ready = 1'b0;
   logic [3:0]  req_ready, req_ready4;
   logic        out_valid, out_valid4, busy, busy4;
   logic [2:0]  out_rem, out_rem4;
   logic [1:0]  out_ch, out_ch4, state_dbg, state_dbg4;
   logic [7:0]  conv_cnt;
   logic [3:0]  conv_cnt4;

   int total = 0;
   int bad = 0;
   bit chk_en = 1'b0;

   // Clock / reset
   always #5 clk = ~clk;

   sensor_mod5_scheduler #(.N_CH(4), .CNT_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
      .req_ready(req_ready), .out_valid(out_valid), .out_ready(out_ready),
      .out_rem(out_rem), .out_ch(out_ch), .busy(busy), .conv_cnt(conv_cnt),
      .state_dbg(state_dbg));

   sensor_mod5_scheduler #(.N_CH(4), .CNT_W(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
      .req_ready(req_ready4), .out_valid(out_valid4), .out_ready(out_ready),
      .out_rem(out_rem4), .out_ch(out_ch4), .busy(busy4), .conv_cnt(conv_cnt4),
      .state_dbg(state_dbg4));

   task automatic check(input string name, input int act, input int want);
      total++;
      if (act != want) begin
         bad++;
         $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, want, $time);
      end
   endtask

   // Scoreboard model: a job is either being converted, waiting downstream,
   // or absent; results are {ch, rem} in exp_q.
   logic [4:0] exp_q[$];
   bit m_compute = 1'b0;
   bit m_valid = 1'b0;
   int m_rr = 0;
   int m_cnt = 0;
   int last_grant = -1;

   function automatic int model_grant();
      int c;
      if (m_compute || m_valid) return -1;
      for (int k = 0; k < N_CH; k++) begin
         c = (m_rr + k) % N_CH;
         if (req_valid[c]) return c;
      end
      return -1;
   endfunction

   always @(negedge clk) begin
      int g, want_rr, nib;
      g = model_grant();
      want_rr = (rst_n && g >= 0) ? (1 << g) : 0;
      if (chk_en) begin
         check("m_req_ready", int'(req_ready), want_rr);
         check("m_out_valid", int'(out_valid), int'(m_valid));
         check("m_busy", int'(busy), int'(m_compute || m_valid));
         check("m_conv_cnt", int'(conv_cnt), m_cnt % 256);
         check("m_conv_cnt4", int'(conv_cnt4), m_cnt % 16);
         if (m_valid && exp_q.size() > 0) begin
            check("m_out_ch", int'(out_ch), int'(exp_q[0][4:3]));
            check("m_out_rem", int'(out_rem), int'(exp_q[0][2:0]));
         end
      end
      last_grant = -1;
      if (!rst_n) begin
         m_compute = 1'b0; m_valid = 1'b0; m_rr = 0; m_cnt = 0;
         exp_q.delete();
      end else if (m_valid) begin
         if (out_ready) begin
            m_valid = 1'b0;
            m_cnt++;
            void'(exp_q.pop_front());
         end
      end else if (m_compute) begin
         m_compute = 1'b0;
         m_valid = 1'b1;
      end else if (g >= 0) begin
         nib = int'(req_data[4*g +: 4]);
         exp_q.push_back({2'(g), 3'(nib % 5)});
         m_rr = (g + 1) % N_CH;
         m_compute = 1'b1;
         last_grant = g;
      end
   end

   // Vector table
   typedef struct {
      logic rst; logic [3:0] v; logic [15:0] d; logic rdy;
      logic chk; logic chk_out;
      logic [3:0] e_rr; logic e_ov; logic [2:0] e_rem; logic [1:0] e_ch;
      logic e_busy; logic [7:0] e_cnt;
   } vec_t;
   vec_t tv[$];

   task automatic add(input logic rst, input logic [3:0] v, input logic [15:0] d,
                      input logic rdy, input logic chk, input logic chk_out,
                      input logic [3:0] e_rr, input logic e_ov, input logic [2:0] e_rem,
                      input logic [1:0] e_ch, input logic e_busy, input logic [7:0] e_cnt);
      vec_t r;
      r = '{rst, v, d, rdy, chk, chk_out, e_rr, e_ov, e_rem, e_ch, e_busy, e_cnt};
      tv.push_back(r);
   endtask

   // Driver tasks
   task automatic drive(input logic rst, input logic [3:0] v, input logic [15:0] d,
                        input logic rdy);
      @(posedge clk); #1;
      rst_n = rst; req_valid = v; req_data = d; out_ready = rdy;
   endtask

   task automatic do_reset();
      drive(1'b0, 4'b0, 16'h0, 1'b0);
      drive(1'b1, 4'b0, 16'h0, 1'b0);
   endtask

   task automatic one_job(input logic [3:0] nib, input int want_rem, input int idx);
      drive(1'b1, 4'b0001, {12'h0, nib}, 1'b1);
      @(negedge clk);
      check($sformatf("ex_grant[%0d]", idx), int'(req_ready), 1);
      drive(1'b1, 4'b0000, 16'h0, 1'b1);
      drive(1'b1, 4'b0000, 16'h0, 1'b1);
      @(negedge clk);
      check($sformatf("ex_valid[%0d]", idx), int'(out_valid), 1);
      check($sformatf("ex_rem[%0d]", idx), int'(out_rem), want_rem);
   endtask

   int rem_tab[16] = '{0, 1, 2, 3, 4, 0, 1, 2, 3, 4, 0, 1, 2, 3, 4, 0};

   initial begin
      vec_t r;
      add(0, 4'b0000, 16'h0000, 0, 0, 0, 4'b0000, 0, 0, 0, 0, 0);
      add(0, 4'b0000, 16'h0000, 0, 1, 1, 4'b0000, 0, 0, 0, 0, 0);
      add(1, 4'b0100, 16'h0D00, 1, 1, 0, 4'b0100, 0, 0, 0, 0, 0);
      add(1, 4'b0000, 16'h0D00, 1, 1, 0, 4'b0000, 0, 0, 0, 1, 0);
      add(1, 4'b0000, 16'h0000, 1, 1, 1, 4'b0000, 1, 3, 2, 1, 0);
      add(1, 4'b0000, 16'h0000, 1, 1, 0, 4'b0000, 0, 0, 0, 0, 1);
      add(1, 4'b0010, 16'h0090, 0, 1, 0, 4'b0010, 0, 0, 0, 0, 1);
      add(1, 4'b0000, 16'h0090, 0, 1, 0, 4'b0000, 0, 0, 0, 1, 1);
      for (int i = 0; i < 10; i++)
         add(1, 4'b1111, 16'h1234, 0, 1, 1, 4'b0000, 1, 4, 1, 1, 1);
      add(1, 4'b1111, 16'h1234, 1, 1, 1, 4'b0000, 1, 4, 1, 1, 1);
      add(1, 4'b1111, 16'h1234, 0, 1, 0, 4'b0100, 0, 0, 0, 0, 2);
      add(1, 4'b1111, 16'h1234, 0, 1, 0, 4'b0000, 0, 0, 0, 1, 2);
      add(1, 4'b1111, 16'h1234, 0, 1, 1, 4'b0000, 1, 2, 2, 1, 2);
      add(0, 4'b1111, 16'h1234, 0, 1, 1, 4'b0000, 1, 2, 2, 1, 2);
      add(1, 4'b1010, 16'h1234, 1, 1, 1, 4'b0010, 0, 0, 0, 0, 0);
      add(1, 4'b0000, 16'h1234, 1, 1, 0, 4'b0000, 0, 0, 0, 1, 0);
      add(1, 4'b0000, 16'h1234, 1, 1, 1, 4'b0000, 1, 3, 1, 1, 0);
      add(1, 4'b0000, 16'h0000, 0, 1, 0, 4'b0000, 0, 0, 0, 0, 1);

      for (int i = 0; i < tv.size(); i++) begin
         r = tv[i];
         drive(r.rst, r.v, r.d, r.rdy);
         if (i >= 1) chk_en = 1'b1;
         @(negedge clk);
         if (r.chk) begin
            check($sformatf("tv_req_ready[%0d]", i), int'(req_ready), int'(r.e_rr));
            check($sformatf("tv_out_valid[%0d]", i), int'(out_valid), int'(r.e_ov));
            check($sformatf("tv_busy[%0d]", i), int'(busy), int'(r.e_busy));
            check($sformatf("tv_conv_cnt[%0d]", i), int'(conv_cnt), int'(r.e_cnt));
            if (r.chk_out) begin
               check($sformatf("tv_out_rem[%0d]", i), int'(out_rem), int'(r.e_rem));
               check($sformatf("tv_out_ch[%0d]", i), int'(out_ch), int'(r.e_ch));
            end
         end
      end

      // Every nibble through ch0, then one more result to wrap the 4-bit counter.
      do_reset();
      for (int i = 0; i < 16; i++) one_job(4'(i), rem_tab[i], i);
      drive(1'b1, 4'b0000, 16'h0, 1'b0);
      @(negedge clk);
      check("ex_conv_cnt", int'(conv_cnt), 16);
      check("ex_conv_cnt4", int'(conv_cnt4), 0);
      one_job(4'd7, 2, 16);
      drive(1'b1, 4'b0000, 16'h0, 1'b0);
      @(negedge clk);
      check("wrap_conv_cnt", int'(conv_cnt), 17);
      check("wrap_conv_cnt4", int'(conv_cnt4), 1);

      // Round-robin with every channel requesting; data = index + 5.
      drive(1'b0, 4'b0, 16'h0, 1'b0);
      drive(1'b1, 4'b1111, 16'h8765, 1'b1);
      for (int n = 0; n < 8; n++) begin
         @(negedge clk);
         check($sformatf("rr_grant[%0d]", n), int'(req_ready), 1 << (n % 4));
         @(posedge clk);
         @(posedge clk);
         @(negedge clk);
         check($sformatf("rr_ch[%0d]", n), int'(out_ch), n % 4);
         check($sformatf("rr_rem[%0d]", n), int'(out_rem), n % 4);
         @(posedge clk); #1;
      end

      // Random traffic: waiting requests hold, the just-granted channel re-rolls.
      for (int n = 0; n < 3000; n++) begin
         @(posedge clk); #1;
         for (int c = 0; c < N_CH; c++) begin
            if (!req_valid[c] || c == last_grant) begin
               req_valid[c] = ($urandom_range(0, 2) != 0);
               req_data[4*c +: 4] = 4'($urandom_range(0, 15));
            end
         end
         out_ready = ($urandom_range(0, 3) != 0);
         rst_n = ($urandom_range(0, 299) != 0);
      end
      @(posedge clk); #1;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
